// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
//   Shares one memory port between an I-cache and a D-cache requester.
//   A registered owner state (IDLE / GNT_I / GNT_D) steers the owner's
//   request onto the mem_* bus combinationally and returns mem_ready and
//   mem_rdata to the owner only. A grant is held for as long as the owner
//   keeps req high, so multi-word line transfers stay together. A beat
//   counter bounds that hold to MAX_BEATS handshakes when the other port
//   is waiting.
//
//   Optional feature (macro ARB_ROUND_ROBIN_EN):
//     defined   - simultaneous requests in IDLE go to the port named by a
//                 1-bit pointer. Every grant entry points it at the port
//                 that was not just granted.
//     undefined - D always wins simultaneous requests, and no pointer exists.
//
// Parameters
//   MAX_BEATS  handshakes an owner may complete before it yields to a
//              waiting port (default 8)
//
// Ports
//   clk, rst                          rising-edge clock, sync active-high reset
//   i_req/i_wr/i_addr/i_wdata    in   I-cache request
//   i_rdata/i_ready              out  I-cache read data / handshake
//   d_req/d_wr/d_addr/d_wdata    in   D-cache request
//   d_rdata/d_ready              out  D-cache read data / handshake
//   mem_req/mem_wr/mem_addr/
//   mem_wdata                    out  shared memory request
//   mem_rdata/mem_ready          in   memory read data / handshake
//   grant                        out  owner: 00 none, 01 I, 10 D
module cache_mem_arbiter #(
  parameter int unsigned MAX_BEATS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic        i_wr,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] i_rdata,
  output logic        i_ready,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [1:0]  grant
);

  localparam int unsigned    BW        = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic [BW-1:0]  BEAT_LAST = BW'(MAX_BEATS - 1);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] GNT_I = 2'b01;
  localparam logic [1:0] GNT_D = 2'b10;

  logic [1:0]    state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic          hs;
  logic [1:0]    both_pick;

`ifdef ARB_ROUND_ROBIN_EN
  // 0: I goes next on a tie, 1: D goes next on a tie.
  logic rr_q, rr_d;
  assign both_pick = rr_q ? GNT_D : GNT_I;
`else
  assign both_pick = GNT_D;
`endif

  assign grant = state_q;
  assign hs    = mem_req && mem_ready;

  // Output steering: only the owner sees the memory bus; IDLE drives all zeros.
  always_comb begin
    mem_req   = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    i_ready   = 1'b0;
    i_rdata   = '0;
    d_ready   = 1'b0;
    d_rdata   = '0;
    case (state_q)
      GNT_I: begin
        mem_req   = i_req;
        mem_wr    = i_wr;
        mem_addr  = i_addr;
        mem_wdata = i_wdata;
        i_ready   = mem_ready && i_req;
        i_rdata   = mem_rdata;
      end
      GNT_D: begin
        mem_req   = d_req;
        mem_wr    = d_wr;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        d_ready   = mem_ready && d_req;
        d_rdata   = mem_rdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: begin
        if (i_req && d_req) state_d = both_pick;
        else if (d_req)     state_d = GNT_D;
        else if (i_req)     state_d = GNT_I;
      end
      GNT_I: begin
        if (!i_req)                                  state_d = d_req ? GNT_D : IDLE;
        else if (hs && (beat_q == BEAT_LAST) && d_req) state_d = GNT_D;
      end
      GNT_D: begin
        if (!d_req)                                  state_d = i_req ? GNT_I : IDLE;
        else if (hs && (beat_q == BEAT_LAST) && i_req) state_d = GNT_I;
      end
      default: state_d = IDLE;
    endcase

    // Counter restarts with each new owner and sticks at BEAT_LAST, so a
    // late-arriving waiter takes over on the very next handshake.
    if (state_d != state_q)              beat_d = '0;
    else if (hs && (beat_q != BEAT_LAST)) beat_d = beat_q + 1'b1;
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    rr_d = rr_q;
    if (state_d != state_q) begin
      if (state_d == GNT_I)      rr_d = 1'b1;
      else if (state_d == GNT_D) rr_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
`ifdef ARB_ROUND_ROBIN_EN
      rr_q    <= rr_d;
`endif
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter
//   Directed bench for cache_mem_arbiter (MAX_BEATS = 8). Read data expected
//   by a requester is queued when memory is driven and popped when the
//   requester's ready is observed. Tie-break expectations follow the
//   ARB_ROUND_ROBIN_EN macro.
module tb_cache_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req, i_wr, d_req, d_wr;
  logic [31:0] i_addr, i_wdata, d_addr, d_wdata;
  logic [31:0] i_rdata, d_rdata;
  logic        i_ready, d_ready;
  logic        mem_req, mem_wr;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready;
  logic [1:0]  grant;

  int n_pass = 0;
  int n_fail = 0;
  int n_chk  = 0;
  logic [31:0] sb[$];

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit TIE_TO_D = 1'b0;
`else
  localparam bit TIE_TO_D = 1'b1;
`endif

  cache_mem_arbiter #(.MAX_BEATS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_wr      (i_wr),
    .i_addr    (i_addr),
    .i_wdata   (i_wdata),
    .i_rdata   (i_rdata),
    .i_ready   (i_ready),
    .d_req     (d_req),
    .d_wr      (d_wr),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_ready   (d_ready),
    .mem_req   (mem_req),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .grant     (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // n handshakes by the owner with mem_ready high every cycle.
  task automatic beats(input bit is_d, input int n, input logic [31:0] step);
    logic [31:0] exp;
    logic [31:0] a, w;
    for (int k = 0; k < n; k++) begin
      mem_rdata = step * (k + 1);
      mem_ready = 1'b1;
      a = (is_d ? 32'h2000 : 32'h1000) + k;
      w = (is_d ? 32'hD000 : 32'hA000) + k;
      if (is_d) begin d_addr = a; d_wdata = w; d_wr = (k < 2); end
      else      begin i_addr = a; i_wdata = w; i_wr = (k < 2); end
      sb.push_back(step * (k + 1));
      #1;
      exp = sb.pop_front();
      chk("grant",     {30'd0, grant}, is_d ? 32'd2 : 32'd1);
      chk("own_ready", {31'd0, is_d ? d_ready : i_ready}, 32'd1);
      chk("own_rdata", is_d ? d_rdata : i_rdata, exp);
      chk("oth_ready", {31'd0, is_d ? i_ready : d_ready}, 32'd0);
      chk("oth_rdata", is_d ? i_rdata : d_rdata, 32'd0);
      chk("mem_addr",  mem_addr, a);
      chk("mem_wdata", mem_wdata, w);
      chk("mem_wr",    {31'd0, mem_wr}, {31'd0, (k < 2)});
      tick();
    end
  endtask

  // Both requests rise together; each side does two beats and releases.
  task automatic tie_round();
    bit first_d;
    first_d = TIE_TO_D;
    i_req = 1'b1;
    d_req = 1'b1;
    mem_ready = 1'b1;
    #1;
    chk("tie_idle_grant", {30'd0, grant}, 32'd0);
    chk("tie_idle_mreq",  {31'd0, mem_req}, 32'd0);
    tick();
    beats(first_d, 2, first_d ? 32'h101 : 32'h11);
    if (first_d) d_req = 1'b0; else i_req = 1'b0;
    #1;
    chk("tie_rel_grant", {30'd0, grant}, first_d ? 32'd2 : 32'd1);
    chk("tie_rel_ready", {31'd0, d_ready | i_ready}, 32'd0);
    tick();
    beats(!first_d, 2, first_d ? 32'h11 : 32'h101);
    i_req = 1'b0;
    d_req = 1'b0;
    tick();
    chk("tie_end_grant", {30'd0, grant}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    i_req = 0; i_wr = 0; i_addr = 0; i_wdata = 0;
    d_req = 0; d_wr = 0; d_addr = 0; d_wdata = 0;
    mem_rdata = 0; mem_ready = 0;
    repeat (2) tick();

    // Reset state; IDLE must mask requester fields and memory data
    rst = 1'b0;
    i_addr = 32'hDEADBEEF; d_wdata = 32'hCAFEF00D; mem_rdata = 32'h55AA55AA; mem_ready = 1'b1;
    #1;
    chk("rst_grant",   {30'd0, grant}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_addr",    mem_addr, 32'd0);
    chk("rst_wdata",   mem_wdata, 32'd0);
    chk("rst_i_ready", {31'd0, i_ready}, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_i_rdata", i_rdata, 32'd0);
    tick();

    // Simultaneous requests, twice
    tie_round();
    tie_round();

    // I-only 4-word read
    i_req = 1'b1; mem_ready = 1'b1;
    #1;
    chk("i4_arb_grant", {30'd0, grant}, 32'd0);
    chk("i4_arb_ready", {31'd0, i_ready}, 32'd0);
    tick();
    beats(1'b0, 4, 32'h11);
    i_req = 1'b0;
    #1;
    chk("i4_rel_grant", {30'd0, grant}, 32'd1);
    chk("i4_rel_mreq",  {31'd0, mem_req}, 32'd0);
    tick();
    chk("i4_idle_grant", {30'd0, grant}, 32'd0);

    // D holds 12 beats while I waits: forced off after 8
    d_req = 1'b1;
    #1;
    tick();
    i_req = 1'b1;
    beats(1'b1, 8, 32'h3);
    beats(1'b0, 2, 32'h7);
    i_req = 1'b0;
    #1;
    chk("fair_rel_grant", {30'd0, grant}, 32'd1);
    chk("fair_d_ready",   {31'd0, d_ready}, 32'd0);
    tick();
    beats(1'b1, 4, 32'h5);
    d_req = 1'b0;
    tick();
    chk("fair_idle_grant", {30'd0, grant}, 32'd0);

    // Counter saturates: after 10 solo D beats, a stall, then I arrives
    d_req = 1'b1;
    #1;
    tick();
    beats(1'b1, 10, 32'h9);
    mem_ready = 1'b0;
    #1;
    chk("stall_grant", {30'd0, grant}, 32'd2);
    chk("stall_ready", {31'd0, d_ready}, 32'd0);
    tick();
    i_req = 1'b1;
    beats(1'b1, 1, 32'hB);
    chk("sat_switch_grant", {30'd0, grant}, 32'd1);
    i_req = 1'b0;
    d_req = 1'b0;
    tick();
    chk("sat_idle_grant", {30'd0, grant}, 32'd0);

    // Reset restores the tie-break pointer
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tie_round();

    // Reset mid-burst in GNT_D
    d_req = 1'b1;
    #1;
    tick();
    beats(1'b1, 2, 32'hE);
    rst = 1'b1;
    tick();
    chk("midrst_grant",   {30'd0, grant}, 32'd0);
    chk("midrst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("midrst_d_ready", {31'd0, d_ready}, 32'd0);
    tick();
    chk("midrst_hold_grant", {30'd0, grant}, 32'd0);
    chk("midrst_hold_ready", {31'd0, d_ready}, 32'd0);
    rst = 1'b0;
    d_req = 1'b0;
    tick();
    chk("midrst_end_grant", {30'd0, grant}, 32'd0);
    chk("midrst_end_ready", {31'd0, d_ready}, 32'd0);

    chk("sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
REQ-001 The block SHALL have one parameter: MAX_BEATS, default 8, the number of handshakes an owner may complete before it is forced off while the other port waits.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 i_req/i_wr  in  1/1  I-cache memory request and write flag.
REQ-006 i_addr/i_wdata  in  32/32  I-cache word address and write data.
REQ-007 i_rdata/i_ready  out  32/1  I-cache read data and handshake.
REQ-008 d_req/d_wr/d_addr/d_wdata  in  1/1/32/32  D-cache request fields.
REQ-009 d_rdata/d_ready  out  32/1  D-cache read data and handshake.
REQ-010 mem_req/mem_wr/mem_addr/mem_wdata  out  1/1/32/32  shared memory request.
REQ-011 mem_rdata/mem_ready  in  32/1  memory read data and handshake.
REQ-012 grant  out  2  current owner: 00 none, 01 I, 10 D.

Function
REQ-013 The block SHALL implement states IDLE, GNT_I and GNT_D, held in a registered state variable; grant SHALL equal the state encoding.
REQ-014 In IDLE, all of the following SHALL be 0: mem_req, mem_wr, mem_addr, mem_wdata, i_ready, d_ready, i_rdata and d_rdata.
REQ-015 In IDLE with any request high, the block SHALL enter the selected GNT state on the next edge, giving 1 cycle of arbitration latency; with none high it SHALL stay in IDLE.
REQ-016 In GNT_x, the owner's req/wr/addr/wdata SHALL drive the mem_* outputs combinationally.
REQ-017 In GNT_x, x_ready SHALL equal mem_ready && x_req and x_rdata SHALL equal mem_rdata, both in the same cycle.
REQ-018 In GNT_x, the non-owner's ready and rdata SHALL be 0.
REQ-019 A handshake SHALL be defined as mem_req && mem_ready; read data SHALL be valid only in the handshake cycle.
REQ-020 The grant SHALL be held while the owner's req stays high, so that a multi-word line transfer (write-back followed by fetch) is not split unless REQ-022 applies.
REQ-021 When the owner's req is low in GNT_x, the next state SHALL be the other port's GNT state if the other req is high, else IDLE.
REQ-022 A beat counter SHALL count handshakes within the current grant; on the handshake at which count reaches MAX_BEATS-1, if the other req is high, the block SHALL switch to the other GNT state on the next edge.
REQ-023 The beat counter SHALL reset to 0 on every state change and SHALL saturate, never wrap, while no switch occurs.
REQ-024 Requester inputs SHALL be assumed held stable until their ready; the block SHALL NOT buffer requests.
REQ-025 A memory handshake SHALL never be forwarded to a non-owner.
REQ-026 Simultaneous requests in IDLE SHALL be resolved per REQ-032/REQ-033.

Reset
REQ-027 While rst is high at an edge, the state SHALL become IDLE and the beat counter 0.
REQ-028 While rst is high at an edge, the round-robin pointer SHALL become "I next".
REQ-029 After reset, all outputs SHALL take their IDLE values (REQ-014) in the following cycle.
REQ-030 A reset asserted mid-transfer SHALL abort the transfer with no further handshake forwarded.
REQ-031 Reset SHALL take priority over all other events.

Configuration
REQ-032 With macro ARB_ROUND_ROBIN_EN defined, simultaneous requests SHALL go to the port indicated by a 1-bit pointer, and the pointer SHALL flip to the other port on every grant entry.
REQ-033 Without ARB_ROUND_ROBIN_EN, D SHALL always win simultaneous requests, and no pointer SHALL exist.

Verification
REQ-034 I-only read, 4 words, mem_ready on every cycle -> grant goes 00 to 01 after 1 cycle; four i_ready pulses deliver the mem_rdata values 0x11, 0x22, 0x33 and 0x44; grant returns to 00 the cycle after i_req falls.
REQ-035 i_req and d_req rise in the same cycle, macro undefined -> grant=10; D completes its transfer, then grant moves directly to 01 with no IDLE cycle.
REQ-036 Same stimulus as REQ-035 twice in succession, macro defined -> first grant goes to I, second grant goes to D.
REQ-037 D holds req for 12 beats while I waits, MAX_BEATS=8 -> after the 8th D handshake grant switches to 01; d_ready stays 0 until I releases its request.
REQ-038 rst is asserted during GNT_D, mid-burst -> next cycle grant=00, mem_req=0 and no further d_ready pulse.
